periph_sink: RTL and testbench

- Receiving end of the CPU's 16-bit PeripheralBuffer output.
- Accepts words written by the core, buffers them in a small FIFO, and presents them to a downstream peripheral over a valid/ready handshake.
- Asserts `full` back to the core so it can stall, and records dropped words.
- Sits between the ImagineThinker core and external peripherals such as a display/LED driver or a UART transmitter.

---
 rtl/periph_pkg.sv | 16 +
 rtl/periph_sink_mem.sv | 58 +++++
 rtl/periph_sink.sv | 131 +++++++++++++
 tb/tb_periph_sink.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// ---------------------------------------------------------------------------
// periph_pkg
// Shared definitions for the peripheral sink slice: the PeripheralBuffer word
// width, the word type, and the width and ceiling of the drop counter.
// Used by periph_sink and periph_sink_mem. No ports.
// ---------------------------------------------------------------------------
package periph_pkg;

    localparam int WORD_W     = 16;
    localparam int DROP_CNT_W = 8;

    typedef logic [WORD_W-1:0] periph_word_t;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/periph_sink_mem.sv
// ---------------------------------------------------------------------------
// periph_sink_mem
// DEPTH x WORD_W word storage for the peripheral sink FIFO. It has one clocked
// write port and one registered read port. The read port is write-first: if
// the address being read is written in the same cycle, the new word is
// returned. This lets a word pushed into an empty FIFO appear at the head one
// cycle later.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (clears rd_data only)
//   wr_en    in   write strobe
//   wr_addr  in   write address (FIFO tail)
//   wr_data  in   word to store
//   rd_en    in   load rd_data from rd_addr this cycle
//   rd_addr  in   read address (next FIFO head)
//   rd_data  out  registered head word
// ---------------------------------------------------------------------------
module periph_sink_mem
    import periph_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    periph_word_t storage [DEPTH];

    // Storage array has no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[wr_addr] <= wr_data;
        end
    end

    // Registered head read, bypassing the write port when both address the
    // same slot so a freshly pushed word is not lost behind the stale entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= storage[rd_addr];
            end
        end
    end

endmodule

// File: rtl/periph_sink.sv
// ---------------------------------------------------------------------------
// periph_sink
// Receiving end of the core's 16-bit PeripheralBuffer output. Words written by
// the core are buffered in a DEPTH-entry FIFO and handed to a downstream
// peripheral over a valid/ready handshake. Writes that arrive while the FIFO
// is full and nothing is leaving are dropped and counted.
//
// Optional build macro: PERIPH_SINK_CHANGE_CAPTURE_EN
//   When defined, wr_en is ignored and a word is written whenever wr_data
//   differs from its registered value of the previous cycle (that register
//   resets to zero), so a level-held PeripheralBuffer needs no strobe.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   wr_en      in   write strobe from the core
//   wr_data    in   word from PeripheralBuffer
//   full       out  FIFO holds DEPTH words (registered)
//   out_valid  out  head word available (registered)
//   out_data   out  head word, held while stalled or empty
//   out_ready  in   downstream accepts the head word
//   count      out  occupancy, 0..DEPTH
//   overflow   out  sticky: at least one word was dropped
//   drop_cnt   out  dropped words, saturating at 255
// ---------------------------------------------------------------------------
module periph_sink
    import periph_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WORD_W-1:0]     wr_data,
    output logic                  full,
    output logic                  out_valid,
    output logic [WORD_W-1:0]     out_data,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_next;
    logic [CNT_W-1:0] count_next;
    logic             write_req;
    logic             push;
    logic             pop;
    logic             drop;
    logic             mem_we;
    logic             mem_re;

`ifdef PERIPH_SINK_CHANGE_CAPTURE_EN
    periph_word_t prev_data;
    logic         unused_wr_en;

    assign unused_wr_en = wr_en;

    // Previous-cycle copy of the bus; any change is treated as a new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_data <= '0;
        end else begin
            prev_data <= wr_data;
        end
    end

    assign write_req = (wr_data != prev_data);
`else
    assign write_req = wr_en;
`endif

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop        = out_valid && out_ready;
    assign push       = write_req && (!full || pop);
    assign drop       = write_req && full && !pop;
    assign head_next  = head + PTR_W'(pop);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // The head register is reloaded from the slot that will be the head after
    // this edge; when the FIFO goes empty it is left alone so out_data holds.
    assign mem_we = push && !rst;
    assign mem_re = (count_next != '0) && !rst;

    periph_sink_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_we),
        .wr_addr (tail),
        .wr_data (wr_data),
        .rd_en   (mem_re),
        .rd_addr (head_next),
        .rd_data (out_data)
    );

    // Pointers wrap naturally because DEPTH is a power of two; flags are
    // registered from the next occupancy so they line up with out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            head      <= head_next;
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            count     <= count_next;
            out_valid <= (count_next != '0);
            full      <= (count_next == CNT_W'(DEPTH));
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != DROP_CNT_MAX) begin
                    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_periph_sink.sv
// ---------------------------------------------------------------------------
// tb_periph_sink
// Self-checking bench for periph_sink. A queue-based model of the FIFO rules
// predicts occupancy, flags and drop counting; every accepted word is also
// pushed to a scoreboard that a separate monitor drains whenever the DUT
// hands a word downstream. Build with PERIPH_SINK_CHANGE_CAPTURE_EN to
// exercise the change-capture write mode.
// ---------------------------------------------------------------------------
module tb_periph_sink;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        out_ready = 1'b0;
    logic        full;
    logic        out_valid;
    logic [15:0] out_data;
    logic [CNT_W-1:0] count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] model_q[$];
    logic [15:0] sb_q[$];
    logic [15:0] model_prev = 16'h0000;
    logic [15:0] model_last = 16'h0000;
    logic [15:0] cur_data   = 16'h0000;
    bit          model_ovf  = 1'b0;
    int          model_drops = 0;
    bit          model_known = 1'b0;

    periph_sink #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkState();
        if (model_q.size() > 0) model_last = model_q[0];
        checkOutput("count",     32'(count),     32'(model_q.size()));
        checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        checkOutput("full",      32'(full),      32'(model_q.size() == DEPTH));
        checkOutput("overflow",  32'(overflow),  32'(model_ovf));
        checkOutput("drop_cnt",  32'(drop_cnt),  32'(model_drops));
        checkOutput("out_data",  32'(out_data),  32'(model_last));
    endtask

    // Applies the FIFO rules for one clock edge with the given inputs.
    task automatic modelStep(input logic r, input logic we, input logic [15:0] d, input logic rdy);
        bit eff_we;
        bit do_pop;
        bit was_full;
        if (r) begin
            model_q.delete();
            sb_q.delete();
            model_prev  = 16'h0000;
            model_last  = 16'h0000;
            model_ovf   = 1'b0;
            model_drops = 0;
            return;
        end
`ifdef PERIPH_SINK_CHANGE_CAPTURE_EN
        eff_we = (d != model_prev);
`else
        eff_we = we;
`endif
        model_prev = d;
        was_full = (model_q.size() == DEPTH);
        do_pop   = (model_q.size() != 0) && rdy;
        if (do_pop) void'(model_q.pop_front());
        if (eff_we) begin
            if (!was_full || do_pop) begin
                model_q.push_back(d);
                sb_q.push_back(d);
            end else begin
                model_ovf = 1'b1;
                if (model_drops < 255) model_drops++;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic we, input logic [15:0] d, input logic rdy);
        @(posedge clk);
        #2;
        rst       = r;
        wr_en     = we;
        wr_data   = d;
        out_ready = rdy;
        cur_data  = d;
        @(negedge clk);
        if (model_known) checkState();
        modelStep(r, we, d, rdy);
        model_known = 1'b1;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, cur_data, 1'b1);
    endtask

    // Monitor: every handshake must deliver the oldest outstanding word.
    initial begin
        logic [15:0] exp_word;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_word: got %0h, expected no output", out_data);
                end else begin
                    exp_word = sb_q.pop_front();
                    checkOutput("out_word", 32'(out_data), 32'(exp_word));
                end
            end
        end
    end

    initial begin
        logic rr;
        logic ww;
        logic [15:0] dd;
        logic rd;
        int accepted;

        $display("[TB] reset and basic write");
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h1234, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h1234, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h1234, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h1234, 1'b0);

        $display("[TB] fill, drop, drain");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 16'(i), 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0009, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0009, 1'b0);
        drain(10);

        $display("[TB] full with simultaneous push and pop");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'h0011 + 16'(i), 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hAAAA, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'hAAAA, 1'b0);
        drain(10);

        $display("[TB] wrap-around stream");
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        accepted = 0;
        for (int cyc = 0; cyc < 200 && accepted < 20; cyc++) begin
            rd = cyc[0];
            ww = (model_q.size() < DEPTH) || (rd && model_q.size() != 0);
            dd = ww ? (16'h0100 + 16'(accepted)) : cur_data;
            applyStimulus(1'b0, ww, dd, rd);
            if (ww) accepted++;
        end
        drain(12);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'h0050 + 16'(i), 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0054, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0);
        drain(3);

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
        for (int i = 0; i < 260; i++) applyStimulus(1'b0, 1'b1, 16'h0300 + 16'(i), 1'b0);
        drain(10);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            ww = 1'($urandom);
            dd = ($urandom_range(0, 3) == 0) ? cur_data : 16'($urandom);
            rd = ($urandom_range(0, 2) != 0);
            applyStimulus(rr, ww, dd, rd);
        end
        drain(12);

`ifdef PERIPH_SINK_CHANGE_CAPTURE_EN
        $display("[TB] change capture");
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 16'h0005, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0007, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0007, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0007, 1'b0);
        checkOutput("capture_count", 32'(count), 32'd2);
        drain(4);
`endif

        checkOutput("words_outstanding", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
